// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller line port between the
// I-cache (port 0) and D-cache (port 1), with a per-request watchdog.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_p0_req,
  input  logic                  i_p0_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [LINE_WIDTH-1:0] i_p0_wdata,
  output logic [LINE_WIDTH-1:0] o_p0_rdata,
  output logic                  o_p0_done,
  output logic                  o_p0_err,
  input  logic                  i_p1_req,
  input  logic                  i_p1_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [LINE_WIDTH-1:0] i_p1_wdata,
  output logic [LINE_WIDTH-1:0] o_p1_rdata,
  output logic                  o_p1_done,
  output logic                  o_p1_err,
  output logic [ADDR_WIDTH-1:0] o_mc_address,
  output logic [LINE_WIDTH-1:0] o_mc_data_in,
  output logic                  o_mc_start_req,
  output logic                  o_mc_wr_en,
  input  logic [LINE_WIDTH-1:0] i_mc_data_out,
  input  logic                  i_mc_data_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  // state  | meaning
  // IDLE   | waiting for a request, arbitrates and latches the winner
  // ISSUE  | start_req raised, watchdog cleared
  // WAIT   | start_req held, waiting for data_valid or watchdog expiry
  // DONE   | one-cycle done/err pulse to the winner
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic                  r_last_grant;
  logic                  r_winner;
  logic [TW-1:0]         r_timer;
  logic [ADDR_WIDTH-1:0] r_mc_address;
  logic [LINE_WIDTH-1:0] r_mc_data_in;
  logic                  r_mc_start_req;
  logic                  r_mc_wr_en;
  logic [LINE_WIDTH-1:0] r_p0_rdata;
  logic [LINE_WIDTH-1:0] r_p1_rdata;
  logic                  r_p0_done;
  logic                  r_p1_done;
  logic                  r_p0_err;
  logic                  r_p1_err;

  logic w_any_req;
  logic w_winner;
  logic w_timeout;

  assign w_any_req = i_p0_req | i_p1_req;
  // On a tie the port that did not win last time is served.
  assign w_winner  = (i_p0_req & i_p1_req) ? ~r_last_grant : i_p1_req;
  assign w_timeout = (r_timer == TIMER_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_last_grant   <= 1'b1;
      r_winner       <= 1'b0;
      r_timer        <= '0;
      r_mc_address   <= '0;
      r_mc_data_in   <= '0;
      r_mc_start_req <= 1'b0;
      r_mc_wr_en     <= 1'b0;
      r_p0_rdata     <= '0;
      r_p1_rdata     <= '0;
      r_p0_done      <= 1'b0;
      r_p1_done      <= 1'b0;
      r_p0_err       <= 1'b0;
      r_p1_err       <= 1'b0;
    end else begin
      r_p0_done <= 1'b0;
      r_p1_done <= 1'b0;
      r_p0_err  <= 1'b0;
      r_p1_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_winner       <= w_winner;
            r_last_grant   <= w_winner;
            r_mc_address   <= w_winner ? i_p1_addr  : i_p0_addr;
            r_mc_data_in   <= w_winner ? i_p1_wdata : i_p0_wdata;
            r_mc_wr_en     <= w_winner ? i_p1_wr_en : i_p0_wr_en;
            r_mc_start_req <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A valid arriving on the expiry cycle still counts as success.
          if (i_mc_data_valid) begin
            if (r_winner) r_p1_rdata <= i_mc_data_out;
            else          r_p0_rdata <= i_mc_data_out;
            r_p0_done      <= ~r_winner;
            r_p1_done      <= r_winner;
            r_mc_start_req <= 1'b0;
            r_state        <= S_DONE;
          end else if (w_timeout) begin
            r_p0_done      <= ~r_winner;
            r_p1_done      <= r_winner;
            r_p0_err       <= ~r_winner;
            r_p1_err       <= r_winner;
            r_mc_start_req <= 1'b0;
            r_state        <= S_DONE;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_p0_rdata     = r_p0_rdata;
  assign o_p1_rdata     = r_p1_rdata;
  assign o_p0_done      = r_p0_done;
  assign o_p1_done      = r_p1_done;
  assign o_p0_err       = r_p0_err;
  assign o_p1_err       = r_p1_err;
  assign o_mc_address   = r_mc_address;
  assign o_mc_data_in   = r_mc_data_in;
  assign o_mc_start_req = r_mc_start_req;
  assign o_mc_wr_en     = r_mc_wr_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a controller model pushes
// expected completions, a monitor checks grants and done pulses against them.
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int LW = 512;
  localparam int T  = 16;
  localparam int N  = 20;

  typedef struct {
    logic          err;
    logic [LW-1:0] data;
    int            lat;
  } outcome_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req;
  logic [1:0]    wr;
  logic [AW-1:0] addr  [2];
  logic [LW-1:0] wdata [2];
  logic [LW-1:0] p0_rdata, p1_rdata;
  logic          p0_done, p1_done, p0_err, p1_err;
  logic [AW-1:0] mc_addr;
  logic [LW-1:0] mc_din;
  logic [LW-1:0] mc_dout;
  logic          mc_start, mc_wr, mc_valid;
  logic [1:0]    done;
  logic [1:0]    err;
  logic [LW-1:0] rdata [2];

  assign done     = {p1_done, p0_done};
  assign err      = {p1_err, p0_err};
  assign rdata[0] = p0_rdata;
  assign rdata[1] = p1_rdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_req(req[0]), .i_p0_wr_en(wr[0]), .i_p0_addr(addr[0]), .i_p0_wdata(wdata[0]),
    .o_p0_rdata(p0_rdata), .o_p0_done(p0_done), .o_p0_err(p0_err),
    .i_p1_req(req[1]), .i_p1_wr_en(wr[1]), .i_p1_addr(addr[1]), .i_p1_wdata(wdata[1]),
    .o_p1_rdata(p1_rdata), .o_p1_done(p1_done), .o_p1_err(p1_err),
    .o_mc_address(mc_addr), .o_mc_data_in(mc_din), .o_mc_start_req(mc_start),
    .o_mc_wr_en(mc_wr), .i_mc_data_out(mc_dout), .i_mc_data_valid(mc_valid)
  );

  int total = 0;
  int bad = 0;
  int completions = 0;
  int grant_q[$];
  outcome_t out_q[$];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Memory controller model: answers each issue after d cycles (d=0 lands in
  // ISSUE, d>T lands after expiry) and records what the requester should see.
  initial begin
    int fixed_d [4];
    int ntx;
    int d;
    int j;
    logic [LW-1:0] data;
    outcome_t o;
    fixed_d = '{10, T, 0, T + 1};
    ntx = 0;
    mc_valid = 1'b0;
    mc_dout = '0;
    wait (rst_n);
    @(negedge clk);
    mc_valid = 1'b1;
    mc_dout = rand_line();
    @(negedge clk);
    mc_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_q.delete();
        mc_valid = 1'b0;
        continue;
      end
      if (mc_start) begin
        d = (ntx < 4) ? fixed_d[ntx] : $urandom_range(0, T + 1);
        ntx++;
        data = (ntx == 1) ? {LW/8{8'hA5}} : rand_line();
        o.err = !(d >= 1 && d <= T);
        o.data = data;
        o.lat = o.err ? T + 1 : d + 1;
        out_q.push_back(o);
        j = 0;
        forever begin
          if (!rst_n) begin
            mc_valid = 1'b0;
            out_q.delete();
            break;
          end
          mc_valid = (j == d);
          if (j == d) mc_dout = data;
          if (j > d && !mc_start) break;
          j++;
          @(negedge clk);
        end
      end
    end
  end

  // Monitor: reference arbitration and completion checking.
  initial begin
    int mdl_last;
    int w;
    int cyc;
    logic prev_start;
    logic [LW-1:0] mdl_rdata [2];
    logic [LW-1:0] exp_data;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] cur_din;
    logic cur_wr;
    outcome_t o;
    mdl_last = 1;
    prev_start = 1'b0;
    mdl_rdata[0] = '0;
    mdl_rdata[1] = '0;
    cyc = 0;
    cur_addr = '0;
    cur_din = '0;
    cur_wr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        grant_q.delete();
        mdl_last = 1;
        prev_start = 1'b0;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        continue;
      end
      cyc++;
      if (mc_start && !prev_start) begin
        check("grant_had_req", LW'(|req), LW'(1));
        if (req == 2'b11) w = 1 - mdl_last;
        else if (req[1]) w = 1;
        else w = 0;
        check("issue_addr", LW'(mc_addr), LW'(addr[w]));
        check("issue_wdata", mc_din, wdata[w]);
        check("issue_wr_en", LW'(mc_wr), LW'(wr[w]));
        mdl_last = w;
        grant_q.push_back(w);
        cur_addr = addr[w];
        cur_din = wdata[w];
        cur_wr = wr[w];
        cyc = 0;
      end else if (mc_start) begin
        check("payload_frozen", LW'({cur_wr, cur_addr}) ^ cur_din, LW'({mc_wr, mc_addr}) ^ mc_din);
      end
      if (done != 2'b00) begin
        check("done_not_both", LW'(done == 2'b11), LW'(0));
        check("start_low_in_done", LW'(mc_start), LW'(0));
        if (grant_q.size() == 0 || out_q.size() == 0) begin
          check("done_expected", LW'(0), LW'(1));
        end else begin
          w = grant_q.pop_front();
          o = out_q.pop_front();
          exp_data = o.err ? mdl_rdata[w] : o.data;
          mdl_rdata[w] = exp_data;
          check("done_port", LW'(done), LW'(2'b01 << w));
          check("done_err", LW'(err), LW'({1'b0, o.err} << w));
          check("done_rdata", rdata[w], exp_data);
          check("done_latency", LW'(cyc), LW'(o.lat));
        end
        completions++;
      end else begin
        check("err_without_done", LW'(err), LW'(0));
      end
      prev_start = mc_start;
    end
  end

  // Requesters and directed phases.
  initial begin
    int served [2];
    int gap [2];
    int cyc;
    int k;
    req = 2'b00;
    wr = 2'b00;
    addr[0] = '0;
    addr[1] = '0;
    wdata[0] = '0;
    wdata[1] = '0;
    served = '{0, 0};
    gap = '{0, 0};
    repeat (3) @(negedge clk);
    check("rst_ctrl", LW'({p0_done, p1_done, p0_err, p1_err, mc_start, mc_wr}), LW'(0));
    check("rst_rdata", p0_rdata | p1_rdata, '0);
    check("rst_mc_addr", LW'(mc_addr), '0);
    check("rst_mc_din", mc_din, '0);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("stale_valid_no_done", LW'(done), LW'(0));
      check("idle_no_start", LW'(mc_start), LW'(0));
    end

    cyc = 0;
    while ((served[0] < N || served[1] < N) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (req[p] && done[p]) begin
          req[p] = 1'b0;
          served[p]++;
          gap[p] = $urandom_range(0, 3);
        end else if (!req[p] && served[p] < N) begin
          if (gap[p] == 0) begin
            req[p] = 1'b1;
            if (served[p] == 0) begin
              wr[p] = (p == 1);
              addr[p] = (p == 1) ? 64'h2040 : 64'h1000;
            end else begin
              wr[p] = 1'($urandom_range(0, 1));
              addr[p] = {$urandom, $urandom} & ~64'h3F;
            end
            wdata[p] = rand_line();
          end else begin
            gap[p]--;
          end
        end
      end
    end
    check("random_phase_in_time", LW'(cyc < 6000), LW'(1));
    check("completions", LW'(completions), LW'(2 * N));

    repeat (3) @(negedge clk);
    req[0] = 1'b1;
    wr[0] = 1'b0;
    addr[0] = 64'h3000;
    wdata[0] = rand_line();
    k = 0;
    while (!mc_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("pre_reset_issue", LW'(mc_start), LW'(1));
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", LW'({p0_done, p1_done, p0_err, p1_err, mc_start, mc_wr}), LW'(0));
    check("async_rst_rdata", p0_rdata | p1_rdata, '0);
    check("async_rst_mc_addr", LW'(mc_addr), '0);
    check("async_rst_mc_din", mc_din, '0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    k = completions;
    cyc = 0;
    while (!done[0] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("regrant_after_reset_done", LW'(done[0]), LW'(1));
    req[0] = 1'b0;
    @(negedge clk);
    check("regrant_completion_counted", LW'(completions), LW'(k + 1));
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
